instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue.sv | 124 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Fetches sequential instruction words from a combinational program memory
// into a small circular queue. The decode stage takes words from the head of
// the queue. A taken branch or jump (redirect) empties the queue and restarts
// fetching at the new address.
//
// Ports
//   clk              sole clock; all state updates on the rising edge
//   reset            asynchronous, active-high reset
//   Fetch_Address_o  byte address presented to program memory (the fetch PC)
//   Instruction_i    program memory word for Fetch_Address_o, same cycle
//   Redirect_i       taken branch/jump: flush the queue and refetch
//   Redirect_PC_i    new fetch address when Redirect_i=1 (forced word aligned)
//   Dequeue_Ready_i  decode stage accepts the head entry this cycle
//   Valid_o          head entry is valid (queue not empty)
//   Instruction_o    head instruction, or NOP when empty
//   PC_o             address of the head instruction, or 0 when empty
//   PC_plus_4_o      PC_o + 4 (modulo 2^32)
//   Count_o          number of valid entries, 0..QUEUE_DEPTH
//   Full_o, Empty_o  Count_o==QUEUE_DEPTH / Count_o==0
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      Fetch_Address_o,
  input  logic [31:0]      Instruction_i,
  input  logic             Redirect_i,
  input  logic [31:0]      Redirect_PC_i,
  input  logic             Dequeue_Ready_i,
  output logic             Valid_o,
  output logic [31:0]      Instruction_o,
  output logic [31:0]      PC_o,
  output logic [31:0]      PC_plus_4_o,
  output logic [CNT_W-1:0] Count_o,
  output logic             Full_o,
  output logic             Empty_o
);

  localparam int               PTR_W     = $clog2(QUEUE_DEPTH);
  localparam logic [31:0]      NOP       = 32'h0000_0013;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] pc_mem    [QUEUE_DEPTH];
  logic [31:0] instr_mem [QUEUE_DEPTH];

  logic full;
  logic valid;
  logic dequeue;
  logic enqueue;

  assign full  = (count == DEPTH_CNT);
  assign valid = (count != '0);

  // Redirect suppresses both operations. When full, an enqueue is only
  // allowed if the head leaves in the same cycle, so the slot it frees is
  // reused immediately.
  assign dequeue = valid & Dequeue_Ready_i & ~Redirect_i;
  assign enqueue = ~Redirect_i & (~full | dequeue);

  // Control state: fetch PC, pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (Redirect_i) begin
      // Low address bits are dropped so fetching stays word aligned.
      fetch_pc <= Redirect_PC_i & ~32'h3;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enqueue) begin
        // Power-of-two depth: pointer wrap is the natural overflow.
        tail     <= tail + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (dequeue) begin
        head <= head + PTR_W'(1);
      end
      case ({enqueue, dequeue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; an entry is only ever observed
  // after being written, because count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= Instruction_i;
    end
  end

  assign Fetch_Address_o = fetch_pc;
  assign Valid_o         = valid;
  assign Count_o         = count;
  assign Full_o          = full;
  assign Empty_o         = ~valid;

  // Head is read straight from storage; empty queue presents a NOP at 0.
  assign Instruction_o = valid ? instr_mem[head] : NOP;
  assign PC_o          = valid ? pc_mem[head]    : 32'h0;
  assign PC_plus_4_o   = PC_o + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: default parameters; b: RESET_PC near the top of the address space;
  // c: depth 2; d: depth 16. All share the control inputs.
  logic [31:0] fetch_a, instr_in_a, instr_a, pc_a, pc4_a;
  logic        valid_a, full_a, empty_a;
  logic [2:0]  count_a;
  logic [31:0] fetch_b, instr_in_b, instr_b, pc_b, pc4_b;
  logic        valid_b, full_b, empty_b;
  logic [2:0]  count_b;
  logic [31:0] fetch_c, instr_in_c, instr_c, pc_c, pc4_c;
  logic        valid_c, full_c, empty_c;
  logic [1:0]  count_c;
  logic [31:0] fetch_d, instr_in_d, instr_d, pc_d, pc4_d;
  logic        valid_d, full_d, empty_d;
  logic [4:0]  count_d;

  // Program memory: each word is the bitwise inverse of its address.
  assign instr_in_a = ~fetch_a;
  assign instr_in_b = ~fetch_b;
  assign instr_in_c = ~fetch_c;
  assign instr_in_d = ~fetch_d;

  instruction_fetch_queue dut_a (
    .clk(clk), .reset(reset), .Fetch_Address_o(fetch_a), .Instruction_i(instr_in_a),
    .Redirect_i(redirect), .Redirect_PC_i(redirect_pc), .Dequeue_Ready_i(ready),
    .Valid_o(valid_a), .Instruction_o(instr_a), .PC_o(pc_a), .PC_plus_4_o(pc4_a),
    .Count_o(count_a), .Full_o(full_a), .Empty_o(empty_a));

  instruction_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .Fetch_Address_o(fetch_b), .Instruction_i(instr_in_b),
    .Redirect_i(redirect), .Redirect_PC_i(redirect_pc), .Dequeue_Ready_i(ready),
    .Valid_o(valid_b), .Instruction_o(instr_b), .PC_o(pc_b), .PC_plus_4_o(pc4_b),
    .Count_o(count_b), .Full_o(full_b), .Empty_o(empty_b));

  instruction_fetch_queue #(.QUEUE_DEPTH(2)) dut_c (
    .clk(clk), .reset(reset), .Fetch_Address_o(fetch_c), .Instruction_i(instr_in_c),
    .Redirect_i(redirect), .Redirect_PC_i(redirect_pc), .Dequeue_Ready_i(ready),
    .Valid_o(valid_c), .Instruction_o(instr_c), .PC_o(pc_c), .PC_plus_4_o(pc4_c),
    .Count_o(count_c), .Full_o(full_c), .Empty_o(empty_c));

  instruction_fetch_queue #(.QUEUE_DEPTH(16)) dut_d (
    .clk(clk), .reset(reset), .Fetch_Address_o(fetch_d), .Instruction_i(instr_in_d),
    .Redirect_i(redirect), .Redirect_PC_i(redirect_pc), .Dequeue_Ready_i(ready),
    .Valid_o(valid_d), .Instruction_o(instr_d), .PC_o(pc_d), .PC_plus_4_o(pc4_d),
    .Count_o(count_d), .Full_o(full_d), .Empty_o(empty_d));

  // One rising edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (count_a !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (valid_a !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    checks++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty_a, full_a); end
    checks++; if (instr_a !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr_a); end
    checks++; if (pc_a !== 32'h0 || pc4_a !== 32'h4) begin errors++; $display("FAIL reset_pc: got %h/%h expected 00000000/00000004", pc_a, pc4_a); end
    checks++; if (fetch_a !== 32'h0040_0000) begin errors++; $display("FAIL reset_fetch: got %h expected 00400000", fetch_a); end
  endtask

  task automatic test_fill();
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b0;
    step();
    checks++; if (valid_a !== 1'b1 || count_a !== 3'd1) begin errors++; $display("FAIL fill_latency: got valid=%b count=%0d expected 1 1", valid_a, count_a); end
    checks++; if (pc_a !== 32'h0040_0000 || instr_a !== 32'hFFBF_FFFF) begin errors++; $display("FAIL fill_head: got %h/%h expected 00400000/ffbfffff", pc_a, instr_a); end
    repeat (3) step();
    checks++; if (full_a !== 1'b1 || count_a !== 3'd4) begin errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1 4", full_a, count_a); end
    checks++; if (fetch_a !== 32'h0040_0010) begin errors++; $display("FAIL fill_fetch: got %h expected 00400010", fetch_a); end
    checks++; if (pc_a !== 32'h0040_0000) begin errors++; $display("FAIL fill_pc: got %h expected 00400000", pc_a); end
    repeat (2) step();
    checks++; if (fetch_a !== 32'h0040_0010 || count_a !== 3'd4 || pc_a !== 32'h0040_0000) begin
      errors++; $display("FAIL full_hold: got fetch=%h count=%0d pc=%h expected 00400010 4 00400000", fetch_a, count_a, pc_a);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'h0040_0000 + 32'(4 * i);
      checks++; if (pc_a !== exp_pc || instr_a !== ~exp_pc) begin errors++; $display("FAIL stream_head[%0d]: got %h/%h expected %h/%h", i, pc_a, instr_a, exp_pc, ~exp_pc); end
      checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 4", i, count_a); end
      step();
    end
    ready = 1'b0;
  endtask

  task automatic test_redirect();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) step();
    checks++; if (count_a !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", count_a); end
    redirect = 1'b1;
    redirect_pc = 32'h0040_0103;
    ready = 1'b1;
    step();
    checks++; if (valid_a !== 1'b0 || count_a !== 3'd0 || empty_a !== 1'b1) begin errors++; $display("FAIL redir_flush: got valid=%b count=%0d empty=%b expected 0 0 1", valid_a, count_a, empty_a); end
    checks++; if (fetch_a !== 32'h0040_0100) begin errors++; $display("FAIL redir_fetch: got %h expected 00400100", fetch_a); end
    checks++; if (instr_a !== 32'h0000_0013) begin errors++; $display("FAIL redir_nop: got %h expected 00000013", instr_a); end
    redirect = 1'b0;
    ready = 1'b0;
    step();
    checks++; if (pc_a !== 32'h0040_0100 || valid_a !== 1'b1) begin errors++; $display("FAIL redir_target: got pc=%h valid=%b expected 00400100 1", pc_a, valid_a); end
  endtask

  task automatic test_async_reset();
    step();
    checks++; if (count_a !== 3'd2) begin errors++; $display("FAIL areset_pre_count: got %0d expected 2", count_a); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count_a !== 3'd0 || valid_a !== 1'b0 || empty_a !== 1'b1 || full_a !== 1'b0) begin
      errors++; $display("FAIL areset_state: got count=%0d valid=%b empty=%b full=%b expected 0 0 1 0", count_a, valid_a, empty_a, full_a);
    end
    checks++; if (instr_a !== 32'h0000_0013 || pc_a !== 32'h0 || fetch_a !== 32'h0040_0000) begin
      errors++; $display("FAIL areset_outputs: got instr=%h pc=%h fetch=%h expected 00000013 00000000 00400000", instr_a, pc_a, fetch_a);
    end
    ready = 1'b1;
    step();
    checks++; if (count_a !== 3'd0 || instr_a !== 32'h0000_0013) begin errors++; $display("FAIL empty_ready: got count=%0d instr=%h expected 0 00000013", count_a, instr_a); end
    reset = 1'b0;
    step();
    checks++; if (count_a !== 3'd1 || pc_a !== 32'h0040_0000) begin errors++; $display("FAIL post_reset_first: got count=%0d pc=%h expected 1 00400000", count_a, pc_a); end
    step();
    checks++; if (count_a !== 3'd1 || pc_a !== 32'h0040_0004) begin errors++; $display("FAIL post_reset_stream: got count=%0d pc=%h expected 1 00400004", count_a, pc_a); end
    ready = 1'b0;
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    checks++; if (pc_b !== 32'hFFFF_FFF8 || pc4_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h/%h expected fffffff8/fffffffc", pc_b, pc4_b); end
    repeat (2) step();
    checks++; if (count_b !== 3'd3 || fetch_b !== 32'h0000_0004) begin errors++; $display("FAIL wrap_fetch: got count=%0d fetch=%h expected 3 00000004", count_b, fetch_b); end
    ready = 1'b1;
    step();
    checks++; if (pc_b !== 32'hFFFF_FFFC || pc4_b !== 32'h0 || count_b !== 3'd3) begin
      errors++; $display("FAIL wrap_second: got pc=%h pc4=%h count=%0d expected fffffffc 00000000 3", pc_b, pc4_b, count_b);
    end
    step();
    checks++; if (pc_b !== 32'h0 || instr_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_third: got %h/%h expected 00000000/ffffffff", pc_b, instr_b); end
    ready = 1'b0;
  endtask

  // Random ready/redirect against independent reference queues for depth 2/16.
  task automatic test_regression();
    logic [31:0] qc[$];
    logic [31:0] qd[$];
    logic [31:0] fpc_c, fpc_d;
    logic        deq, enq;
    reset = 1'b1;
    #1 reset = 1'b0;
    fpc_c = 32'h0040_0000;
    fpc_d = 32'h0040_0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (count_c !== 2'(qc.size()) || fetch_c !== fpc_c) begin
        errors++; $display("FAIL rand2_state[%0d]: got count=%0d fetch=%h expected %0d %h", cyc, count_c, fetch_c, qc.size(), fpc_c);
      end
      checks++; if (valid_c !== (qc.size() != 0) || (qc.size() != 0 && (pc_c !== qc[0] || instr_c !== ~qc[0]))) begin
        errors++; $display("FAIL rand2_head[%0d]: got valid=%b pc=%h instr=%h expected size %0d", cyc, valid_c, pc_c, instr_c, qc.size());
      end
      checks++; if (count_d !== 5'(qd.size()) || fetch_d !== fpc_d) begin
        errors++; $display("FAIL rand16_state[%0d]: got count=%0d fetch=%h expected %0d %h", cyc, count_d, fetch_d, qd.size(), fpc_d);
      end
      checks++; if (valid_d !== (qd.size() != 0) || (qd.size() != 0 && (pc_d !== qd[0] || instr_d !== ~qd[0]))) begin
        errors++; $display("FAIL rand16_head[%0d]: got valid=%b pc=%h instr=%h expected size %0d", cyc, valid_d, pc_d, instr_d, qd.size());
      end
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      // Depth-2 model
      deq = (qc.size() != 0) && ready && !redirect;
      enq = !redirect && (qc.size() < 2 || deq);
      if (redirect) begin
        qc.delete();
        fpc_c = redirect_pc & ~32'h3;
      end else begin
        if (deq) void'(qc.pop_front());
        if (enq) begin qc.push_back(fpc_c); fpc_c = fpc_c + 32'd4; end
      end
      // Depth-16 model
      deq = (qd.size() != 0) && ready && !redirect;
      enq = !redirect && (qd.size() < 16 || deq);
      if (redirect) begin
        qd.delete();
        fpc_d = redirect_pc & ~32'h3;
      end else begin
        if (deq) void'(qd.pop_front());
        if (enq) begin qd.push_back(fpc_d); fpc_d = fpc_d + 32'd4; end
      end
      step();
    end
    redirect = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_async_reset();
    test_wrap();
    test_regression();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
